// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SLL   = 4'b0011;
    localparam logic [3:0] ALU_SRL   = 4'b0100;
    localparam logic [3:0] ALU_SRA   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_DIVU  = 4'b1010;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_XOR   = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
module alu_muldiv_iter import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             run_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     madd;
    logic [WIDTH:0]     rsh;
    logic [WIDTH:0]     dsub;

    // acc holds {hi, lo}: product/multiplier for MULTU, remainder/quotient for DIVU
    always_comb begin
        madd  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rsh   = acc_q[2*WIDTH-1:WIDTH-1];
        dsub  = rsh - {1'b0, opnd_q};
        acc_d = acc_q;
        if (div_i) begin
            if (!dsub[WIDTH])
                acc_d = {dsub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_d = {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_d = {madd, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            acc_q  <= {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
            opnd_q <= div_i ? b_i : a_i;
            cnt_q  <= CW'(WIDTH);
        end else if (run_i && cnt_q != '0) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_q - 1'b1;
        end
    end

    // Final step's value is exposed combinationally so the top registers it on the same edge
    assign done_o = run_i && (cnt_q == CW'(1));
    assign lo_o   = acc_d[WIDTH-1:0];
    assign hi_o   = acc_d[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative MULTU/DIVU.
module alu_mc import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow
);

    localparam int SW = $clog2(WIDTH);

    state_t           state_q;
    logic             ready_q, valid_q, zero_q, ovf_q;
    logic [WIDTH-1:0] res_q, hi_q;

    logic [WIDTH-1:0] sum, dif, sc_res;
    logic [SW-1:0]    shamt;
    logic             sc_ovf;
    logic             is_mul, is_div, md_div;
    logic             md_done;
    logic [WIDTH-1:0] md_lo, md_hi;

    assign sum   = in_1 + in_2;
    assign dif   = in_1 - in_2;
    assign shamt = in_2[SW-1:0];

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (control)
            ALU_AND:  sc_res = in_1 & in_2;
            ALU_OR:   sc_res = in_1 | in_2;
            ALU_NOR:  sc_res = ~(in_1 | in_2);
            ALU_XOR:  sc_res = in_1 ^ in_2;
            ALU_ADD: begin
                sc_res = sum;
                sc_ovf = (in_1[WIDTH-1] == in_2[WIDTH-1])
                      && (sum[WIDTH-1] != in_1[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_res = dif;
                sc_ovf = (in_1[WIDTH-1] != in_2[WIDTH-1])
                      && (dif[WIDTH-1] != in_1[WIDTH-1]);
            end
            ALU_SLT:
                sc_res = {{(WIDTH-1){1'b0}}, ($signed(in_1) < $signed(in_2))};
            ALU_SLTU:
                sc_res = {{(WIDTH-1){1'b0}}, (in_1 < in_2)};
            ALU_SLL:  sc_res = in_1 << shamt;
            ALU_SRL:  sc_res = in_1 >> shamt;
            ALU_SRA:  sc_res = $signed(in_1) >>> shamt;
            default: begin
                sc_res = '0;
                sc_ovf = 1'b0;
            end
        endcase
    end

    assign is_mul = (state_q == IDLE) && start && (control == ALU_MULTU);
    assign is_div = (state_q == IDLE) && start && (control == ALU_DIVU);
    assign md_div = (state_q == IDLE) ? (control == ALU_DIVU)
                                      : (state_q == DIV);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load_i (is_mul || is_div),
        .run_i  (state_q != IDLE),
        .div_i  (md_div),
        .a_i    (in_1),
        .b_i    (in_2),
        .done_o (md_done),
        .lo_o   (md_lo),
        .hi_o   (md_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_mul) begin
                        state_q <= MUL;
                        ready_q <= 1'b0;
                    end else if (is_div) begin
                        state_q <= DIV;
                        ready_q <= 1'b0;
                    end else if (start) begin
                        valid_q <= 1'b1;
                        res_q   <= sc_res;
                        hi_q    <= '0;
                        zero_q  <= (sc_res == '0);
                        ovf_q   <= sc_ovf;
                    end
                end
                MUL, DIV: begin
                    if (md_done) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b1;
                        res_q   <= md_lo;
                        hi_q    <= md_hi;
                        zero_q  <= (md_lo == '0);
                        ovf_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign valid     = valid_q;
    assign result    = res_q;
    assign result_hi = hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32 and WIDTH=8.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, st;
    logic [3:0]  ctl;
    logic [31:0] a, b;
    logic        rdy, vld, zr, ov;
    logic [31:0] res, rhi;

    logic        rst8, st8;
    logic [3:0]  ctl8;
    logic [7:0]  a8, b8;
    logic        rdy8, vld8, zr8, ov8;
    logic [7:0]  res8, rhi8;

    alu_mc #(.WIDTH(32)) u32 (
        .clk(clk), .reset(rst), .start(st), .control(ctl),
        .in_1(a), .in_2(b), .ready(rdy), .valid(vld),
        .result(res), .result_hi(rhi), .zero(zr), .overflow(ov)
    );

    alu_mc #(.WIDTH(8)) u8 (
        .clk(clk), .reset(rst8), .start(st8), .control(ctl8),
        .in_1(a8), .in_2(b8), .ready(rdy8), .valid(vld8),
        .result(res8), .result_hi(rhi8), .zero(zr8), .overflow(ov8)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } vec_t;

    vec_t vecs[14];

    // Issue a MULTU/DIVU at WIDTH=32, poke ignored starts while busy, check result.
    task automatic mc_op(input string name, input logic [3:0] c,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] elo, input logic [31:0] ehi);
        int n;
        ctl = c; a = x; b = y; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        chk({name, "_busy"}, rdy, 0);
        n = 0;
        do begin
            if (n == 4) begin
                st = 1'b1; ctl = ALU_ADD; a = 32'h1; b = 32'h2;
            end
            if (n == 6) st = 1'b0;
            @(posedge clk); #1;
            n++;
            if (n == 16) chk({name, "_busy_mid"}, rdy, 0);
        end while (!vld && n < 100);
        chk({name, "_lat"}, n, 32);
        chk({name, "_lo"}, res, elo);
        chk({name, "_hi"}, rhi, ehi);
        chk({name, "_zero"}, zr, (elo == 0));
        chk({name, "_ovf"}, ov, 0);
        chk({name, "_rdy"}, rdy, 1);
        @(posedge clk); #1;
        chk({name, "_pulse"}, vld, 0);
    endtask

    initial begin
        int n;
        logic seen;

        vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vecs[1]  = '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        vecs[3]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[4]  = '{ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0};
        vecs[5]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[6]  = '{ALU_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0};
        vecs[7]  = '{ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[8]  = '{ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0};
        vecs[9]  = '{ALU_SLL,  32'h00000001, 32'h00000023, 32'h00000008, 1'b0, 1'b0};
        vecs[10] = '{ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0};
        vecs[11] = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[12] = '{4'b1111,  32'h00000005, 32'h00000006, 32'h00000000, 1'b1, 1'b0};
        vecs[13] = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};

        rst = 1'b1; st = 1'b0; ctl = '0; a = '0; b = '0;
        rst8 = 1'b1; st8 = 1'b0; ctl8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", rdy, 1);
        chk("rst_valid", vld, 0);
        chk("rst_result", res, 0);
        chk("rst_hi", rhi, 0);
        chk("rst_zero", zr, 1);
        chk("rst_ovf", ov, 0);
        rst = 1'b0; rst8 = 1'b0;

        // Single-cycle table, issued back to back
        for (int i = 0; i < 14; i++) begin
            ctl = vecs[i].ctl; a = vecs[i].a; b = vecs[i].b; st = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), vld, 1);
            chk($sformatf("v%0d_res", i), res, vecs[i].res);
            chk($sformatf("v%0d_hi", i), rhi, 0);
            chk($sformatf("v%0d_zero", i), zr, vecs[i].zero);
            chk($sformatf("v%0d_ovf", i), ov, vecs[i].ovf);
            chk($sformatf("v%0d_ready", i), rdy, 1);
        end
        st = 1'b0;
        @(posedge clk); #1;
        chk("sc_pulse", vld, 0);
        chk("sc_hold", res, 0);
        chk("sc_hold_zero", zr, 1);

        mc_op("mul_max", ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h00000001, 32'hFFFFFFFE);
        mc_op("div_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
        mc_op("div_by0", ALU_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9);
        mc_op("mul_zero", ALU_MULTU, 32'd0, 32'h1234, 32'd0, 32'd0);
        mc_op("mul_mix", ALU_MULTU, 32'h00012345, 32'h00010000,
              32'h23450000, 32'h00000001);

        // Reset in the middle of a DIVU discards it
        ctl = ALU_DIVU; a = 32'd100; b = 32'd7; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_ready", rdy, 1);
        chk("mrst_valid", vld, 0);
        chk("mrst_result", res, 0);
        chk("mrst_hi", rhi, 0);
        chk("mrst_zero", zr, 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (vld) seen = 1'b1;
        end
        chk("mrst_novalid", seen, 0);

        // Reset and start together: reset wins
        rst = 1'b1; st = 1'b1; ctl = ALU_ADD; a = 32'd1; b = 32'd1;
        @(posedge clk); #1;
        rst = 1'b0; st = 1'b0;
        @(posedge clk); #1;
        chk("rst_start_valid", vld, 0);
        chk("rst_start_res", res, 0);

        // WIDTH=8 back-to-back: MULTU then ADD in the valid cycle
        ctl8 = ALU_MULTU; a8 = 8'd15; b8 = 8'd17; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        chk("w8_busy", rdy8, 0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!vld8 && n < 50);
        chk("w8_mul_lat", n, 8);
        chk("w8_mul_lo", res8, 8'hFF);
        chk("w8_mul_hi", rhi8, 8'h00);
        chk("w8_mul_rdy", rdy8, 1);
        ctl8 = ALU_ADD; a8 = 8'd3; b8 = 8'd4; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        chk("w8_add_valid", vld8, 1);
        chk("w8_add_res", res8, 8'd7);
        chk("w8_add_hi", rhi8, 8'd0);
        @(posedge clk); #1;
        chk("w8_add_pulse", vld8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
